// File: rtl/processing_element.sv
// -----------------------------------------------------------------------------
// processing_element
//
// One cell of a systolic convolution mesh. Each cell holds a private kernel
// memory and a private neuron memory, loaded through per-row / per-column
// buffers, and on COMPUTE cycles adds one kernel*neuron product to the partial
// sum travelling left-to-right through the row. Three nested counters walk the
// local memories:
//   kCnt  : position inside the current kernel window (0 .. kernelStep-1)
//   cd    : convolution divider, counts kernel windows per neuron window
//   rc    : row counter, counts neuron advances per kernel window advance
//
// Ports
//   CLK            in   1                 clock, rising edge
//   RESETn         in   1                 asynchronous active-low reset
//   adderIn        in   W                 partial sum from the left neighbour
//   adderOut       out  W                 registered partial sum to the right
//   columnControl  in   8                 [7:6] op, [5] start, [4:0] ignored
//   rowControl     in   depth             [0] row enable, upper bits ignored
//   commonControl  in   3*depth+2*A       {Tc, Tr, kernelStep, neuronStep,
//                                          convDivIniValue}
//   kernelIn       in   W                 kernel word from row kernel buffer
//   neuronIn       in   W                 neuron word from column neuron buffer
// -----------------------------------------------------------------------------
module processing_element #(
  parameter int depth = 2,
  parameter int W     = 8,
  parameter int A     = 7
) (
  input  logic                     CLK,
  input  logic                     RESETn,
  input  logic [W-1:0]             adderIn,
  output logic [W-1:0]             adderOut,
  input  logic [7:0]               columnControl,
  input  logic [depth-1:0]         rowControl,
  input  logic [3*depth+2*A-1:0]   commonControl,
  input  logic [W-1:0]             kernelIn,
  input  logic [W-1:0]             neuronIn
);

  typedef enum logic [1:0] {
    OP_NOP         = 2'b00,
    OP_LOAD_KERNEL = 2'b01,
    OP_LOAD_NEURON = 2'b10,
    OP_COMPUTE     = 2'b11
  } op_e;

  localparam int MemWords = 2 ** A;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  op_e              op;
  logic             start;
  logic             row_en;
  logic [depth-1:0] tc;
  logic [depth-1:0] tr;
  logic [A-1:0]     kernel_step;
  logic [A-1:0]     neuron_step;
  logic [depth-1:0] cd_ini;

  assign op     = op_e'(columnControl[7:6]);
  assign start  = columnControl[5];
  assign row_en = rowControl[0];

  assign {tc, tr, kernel_step, neuron_step, cd_ini} = commonControl;

  // Reserved control bits are deliberately ignored.
  logic unused_ctrl;
  assign unused_ctrl = ^{columnControl[4:0], rowControl};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [W-1:0]     adder_out_q, adder_out_d;
  logic [A-1:0]     wk_q, wk_d;
  logic [A-1:0]     wn_q, wn_d;
  logic [A-1:0]     kbase_q, kbase_d;
  logic [A-1:0]     nbase_q, nbase_d;
  logic [A-1:0]     kcnt_q, kcnt_d;
  logic [depth-1:0] cd_q, cd_d;
  logic [depth-1:0] rc_q, rc_d;

  logic [W-1:0]     k_mem_q [MemWords];
  logic [W-1:0]     n_mem_q [MemWords];

  logic             k_we;
  logic             n_we;

  // ---------------------------------------------------------------------------
  // Datapath: combinational memory read and truncated signed MAC
  // ---------------------------------------------------------------------------
  logic [A-1:0]          k_addr;
  logic [A-1:0]          n_addr;
  logic signed [W-1:0]   k_rd;
  logic signed [W-1:0]   n_rd;
  logic signed [2*W-1:0] prod_full;
  logic [W-1:0]          product;
  logic [W-1:0]          mac_sum;

  // Base + offset addition wraps naturally in A bits.
  assign k_addr    = kbase_q + kcnt_q;
  assign n_addr    = nbase_q + kcnt_q;
  assign k_rd      = k_mem_q[k_addr];
  assign n_rd      = n_mem_q[n_addr];
  assign prod_full = k_rd * n_rd;
  assign product   = prod_full[W-1:0];
  assign mac_sum   = adderIn + product;

  // Terminal counts. Subtracting one in the counter's own width makes a step
  // of 0 behave as the full modulus (2^A or 2^depth) with no special case.
  logic [A-1:0]     kcnt_last;
  logic [depth-1:0] cd_last;
  logic [depth-1:0] rc_last;

  assign kcnt_last = kernel_step - 1'b1;
  assign cd_last   = tc - 1'b1;
  assign rc_last   = tr - 1'b1;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case/if tree can leave it unassigned and infer a latch.
  always_comb begin
    adder_out_d = adderIn;
    wk_d        = wk_q;
    wn_d        = wn_q;
    kbase_d     = kbase_q;
    nbase_d     = nbase_q;
    kcnt_d      = kcnt_q;
    cd_d        = cd_q;
    rc_d        = rc_q;
    k_we        = 1'b0;
    n_we        = 1'b0;

    if (start) begin
      // Start re-arms all pointers; the op field is ignored this cycle.
      wk_d    = '0;
      wn_d    = '0;
      kbase_d = '0;
      nbase_d = '0;
      kcnt_d  = '0;
      rc_d    = '0;
      cd_d    = cd_ini;
    end else begin
      unique case (op)
        OP_LOAD_KERNEL: begin
          if (row_en) begin
            k_we = 1'b1;
            wk_d = wk_q + 1'b1;
          end
        end
        OP_LOAD_NEURON: begin
          // Neuron words arrive per column, so the row enable does not gate them.
          n_we = 1'b1;
          wn_d = wn_q + 1'b1;
        end
        OP_COMPUTE: begin
          if (row_en) begin
            adder_out_d = mac_sum;
            if (kcnt_q == kcnt_last) begin
              kcnt_d = '0;
              if (cd_q == cd_last) begin
                cd_d    = '0;
                nbase_d = nbase_q + neuron_step;
                if (rc_q == rc_last) begin
                  rc_d    = '0;
                  kbase_d = kbase_q + kernel_step;
                end else begin
                  rc_d = rc_q + 1'b1;
                end
              end else begin
                cd_d = cd_q + 1'b1;
              end
            end else begin
              kcnt_d = kcnt_q + 1'b1;
            end
          end
        end
        default: ;  // OP_NOP: pass-through only
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      adder_out_q <= '0;
      wk_q        <= '0;
      wn_q        <= '0;
      kbase_q     <= '0;
      nbase_q     <= '0;
      kcnt_q      <= '0;
      cd_q        <= '0;
      rc_q        <= '0;
    end else begin
      adder_out_q <= adder_out_d;
      wk_q        <= wk_d;
      wn_q        <= wn_d;
      kbase_q     <= kbase_d;
      nbase_q     <= nbase_d;
      kcnt_q      <= kcnt_d;
      cd_q        <= cd_d;
      rc_q        <= rc_d;
    end
  end

  // NOTE: the local memories sit in their own clocked block with no reset so
  // they map onto plain RAM; their contents survive RESETn.
  always_ff @(posedge CLK) begin
    if (k_we) k_mem_q[wk_q] <= kernelIn;
    if (n_we) n_mem_q[wn_q] <= neuronIn;
  end

  assign adderOut = adder_out_q;

endmodule

// File: tb/tb_processing_element.sv
module tb_processing_element;

  localparam int DEPTH = 2;
  localparam int W     = 8;
  localparam int A     = 7;
  localparam int CCW   = 3 * DEPTH + 2 * A;

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] LDK = 2'b01;
  localparam logic [1:0] LDN = 2'b10;
  localparam logic [1:0] CMP = 2'b11;

  logic             CLK;
  logic             RESETn;
  logic [W-1:0]     adderIn;
  logic [W-1:0]     adderOut;
  logic [7:0]       columnControl;
  logic [DEPTH-1:0] rowControl;
  logic [CCW-1:0]   commonControl;
  logic [W-1:0]     kernelIn;
  logic [W-1:0]     neuronIn;

  processing_element #(.depth(DEPTH), .W(W), .A(A)) dut (
    .CLK           (CLK),
    .RESETn        (RESETn),
    .adderIn       (adderIn),
    .adderOut      (adderOut),
    .columnControl (columnControl),
    .rowControl    (rowControl),
    .commonControl (commonControl),
    .kernelIn      (kernelIn),
    .neuronIn      (neuronIn)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests;
  int fails;

  // Scoreboard of expected adderOut values, one per driven cycle.
  logic [W-1:0] sb_q[$];

  // Reference model state (plain integers, modular arithmetic done by hand).
  logic signed [W-1:0] km [128];
  logic signed [W-1:0] nm [128];
  int m_wk, m_wn, m_kb, m_nb, m_kc, m_cd, m_rc;
  int c_tc, c_tr, c_ks, c_ns, c_cdi;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: adderOut=%0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cc(input int tc, input int tr, input int ks, input int ns, input int cdi);
    logic [DEPTH-1:0] tc_b, tr_b, cdi_b;
    logic [A-1:0]     ks_b, ns_b;
    c_tc = tc; c_tr = tr; c_ks = ks; c_ns = ns; c_cdi = cdi;
    tc_b = DEPTH'(tc); tr_b = DEPTH'(tr); cdi_b = DEPTH'(cdi);
    ks_b = A'(ks);     ns_b = A'(ns);
    commonControl = {tc_b, tr_b, ks_b, ns_b, cdi_b};
  endtask

  task automatic model_reset();
    m_wk = 0; m_wn = 0; m_kb = 0; m_nb = 0; m_kc = 0; m_cd = 0; m_rc = 0;
  endtask

  // Computes the adderOut expected after this edge and advances the model.
  task automatic model_cycle(input logic [1:0] op, input logic st, input logic row,
                             input logic [W-1:0] ain, input logic [W-1:0] kin,
                             input logic [W-1:0] nin, output logic [W-1:0] exp);
    int kse, tce, tre, p;
    exp = ain;
    if (st) begin
      m_wk = 0; m_wn = 0; m_kb = 0; m_nb = 0; m_kc = 0; m_rc = 0;
      m_cd = c_cdi;
    end else if (op == LDK && row) begin
      km[m_wk] = kin;
      m_wk = (m_wk + 1) % 128;
    end else if (op == LDN) begin
      nm[m_wn] = nin;
      m_wn = (m_wn + 1) % 128;
    end else if (op == CMP && row) begin
      p   = int'(km[(m_kb + m_kc) % 128]) * int'(nm[(m_nb + m_kc) % 128]);
      exp = ain + p[W-1:0];
      kse = (c_ks == 0) ? 128 : c_ks;
      tce = (c_tc == 0) ? 4 : c_tc;
      tre = (c_tr == 0) ? 4 : c_tr;
      if (m_kc == kse - 1) begin
        m_kc = 0;
        if (m_cd == tce - 1) begin
          m_cd = 0;
          m_nb = (m_nb + c_ns) % 128;
          if (m_rc == tre - 1) begin
            m_rc = 0;
            m_kb = (m_kb + c_ks) % 128;
          end else begin
            m_rc = (m_rc + 1) % 4;
          end
        end else begin
          m_cd = (m_cd + 1) % 4;
        end
      end else begin
        m_kc = (m_kc + 1) % 128;
      end
    end
  endtask

  // Drive one cycle, push the model's expectation, pop and compare after the edge.
  task automatic step(input string tag, input logic [1:0] op, input logic st,
                      input logic row, input logic [W-1:0] ain,
                      input logic [W-1:0] kin, input logic [W-1:0] nin);
    logic [W-1:0] e;
    logic [W-1:0] popped;
    columnControl = {op, st, 5'b00000};
    rowControl    = {1'b0, row};
    adderIn       = ain;
    kernelIn      = kin;
    neuronIn      = nin;
    model_cycle(op, st, row, ain, kin, nin, e);
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    popped = sb_q.pop_front();
    check(tag, adderOut, popped);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    RESETn        = 1'b0;
    adderIn       = '0;
    columnControl = '0;
    rowControl    = '0;
    kernelIn      = '0;
    neuronIn      = '0;
    set_cc(0, 0, 2, 0, 0);
    model_reset();

    #12;
    check("reset_state", adderOut, 8'h00);
    #1;
    RESETn = 1'b1;

    // Pass-through: NOP and COMPUTE with the row disabled.
    step("nop_3", NOP, 1'b0, 1'b0, 8'd3, 8'd0, 8'd0);
    step("nop_5", NOP, 1'b0, 1'b0, 8'd5, 8'd0, 8'd0);
    check("nop_5_const", adderOut, 8'd5);
    step("nop_9", NOP, 1'b0, 1'b0, 8'd9, 8'd0, 8'd0);
    step("cmp_row0_5", CMP, 1'b0, 1'b0, 8'd5, 8'd0, 8'd0);
    check("cmp_row0_const", adderOut, 8'd5);

    // Kernel loads, with one row-gated write in between.
    step("ldk_2", LDK, 1'b0, 1'b1, 8'd0, 8'd2, 8'd0);
    step("ldk_3", LDK, 1'b0, 1'b1, 8'd0, 8'd3, 8'd0);
    step("ldk_gated_9", LDK, 1'b0, 1'b0, 8'd0, 8'd9, 8'd0);
    step("ldk_6", LDK, 1'b0, 1'b1, 8'd0, 8'd6, 8'd0);
    step("ldn_4", LDN, 1'b0, 1'b0, 8'd0, 8'd0, 8'd4);
    step("ldn_5", LDN, 1'b0, 1'b1, 8'd0, 8'd0, 8'd5);
    step("ldn_1", LDN, 1'b0, 1'b0, 8'd0, 8'd0, 8'd1);

    // MAC over a 3-word window.
    set_cc(0, 0, 3, 0, 0);
    step("start_mac", NOP, 1'b1, 1'b0, 8'd7, 8'd0, 8'd0);
    step("mac_0", CMP, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
    check("mac_0_const", adderOut, 8'd8);
    step("mac_10", CMP, 1'b0, 1'b1, 8'd10, 8'd0, 8'd0);
    check("mac_10_const", adderOut, 8'd25);
    step("mac_gate", CMP, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
    check("row_gating_const", adderOut, 8'd6);
    step("mac_kwrap", CMP, 1'b0, 1'b1, 8'd1, 8'd0, 8'd0);
    check("kernel_wrap_const", adderOut, 8'd9);

    // Two's-complement wrap of the sum and of the product.
    step("start_wrap", NOP, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    step("ldk_1", LDK, 1'b0, 1'b1, 8'd0, 8'd1, 8'd0);
    step("ldk_m128", LDK, 1'b0, 1'b1, 8'd0, 8'h80, 8'd0);
    step("ldn_1b", LDN, 1'b0, 1'b0, 8'd0, 8'd0, 8'd1);
    step("ldn_2", LDN, 1'b0, 1'b0, 8'd0, 8'd0, 8'd2);
    set_cc(0, 0, 2, 0, 0);
    step("start_wrap2", NOP, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    step("wrap_sum", CMP, 1'b0, 1'b1, 8'd127, 8'd0, 8'd0);
    check("wrap_sum_const", adderOut, 8'h80);
    step("wrap_prod", CMP, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
    check("wrap_prod_const", adderOut, 8'h00);

    // Nested stepping: k[i]=i+1, n[i]=3i+1.
    step("start_load", NOP, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 8; i++)
      step("ldk_step", LDK, 1'b0, 1'b1, 8'd0, 8'(i + 1), 8'd0);
    for (int i = 0; i < 12; i++)
      step("ldn_step", LDN, 1'b0, 1'b1, 8'd0, 8'd0, 8'(3 * i + 1));
    set_cc(2, 2, 4, 4, 0);
    step("start_step", NOP, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    for (int i = 1; i <= 17; i++) begin
      step("cmp_step", CMP, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
      if (i == 5)  check("step_cd1_nbase0", adderOut, 8'd1);
      if (i == 9)  check("step_nbase4_rc1", adderOut, 8'd13);
      if (i == 17) check("step_kbase4_nbase8", adderOut, 8'd125);
    end

    // Asynchronous reset in the middle of a COMPUTE cycle.
    columnControl = {CMP, 1'b0, 5'b00000};
    rowControl    = 2'b01;
    adderIn       = 8'd50;
    #3;
    RESETn = 1'b0;
    #1;
    check("async_reset", adderOut, 8'h00);
    model_reset();
    @(posedge CLK);
    #1;
    check("reset_hold", adderOut, 8'h00);
    RESETn = 1'b1;
    // Memories keep their contents: k[0]*n[0] = 1 with pointers back at 0.
    step("post_reset_mac", CMP, 1'b0, 1'b1, 8'd20, 8'd0, 8'd0);
    check("mem_retained_const", adderOut, 8'd21);
    step("post_reset_nop", NOP, 1'b0, 1'b0, 8'd4, 8'd0, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/processing_element.md
PROCESSING_ELEMENT -- requirements
Module: processing_element

Interface
REQ-001 Parameter depth, default 2: log2 of mesh dimension; width of Tr, Tc, convDivIniValue and rowControl.
REQ-002 Parameter W, default 8: data word width, two's complement.
REQ-003 Parameter A, default 7: local address width; each local memory holds 2^A words.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 CLK  input  1  clock; all state updates on rising edge.
REQ-006 RESETn  input  1  asynchronous active-low reset.
REQ-007 adderIn  input  W  partial sum from the left neighbour.
REQ-008 adderOut  output  W  registered partial sum to the right neighbour.
REQ-009 columnControl  input  8  per-column instruction: [7:6] op (00 NOP, 01 LOAD_KERNEL, 10 LOAD_NEURON, 11 COMPUTE), [5] start, [4:0] reserved and ignored.
REQ-010 rowControl  input  depth  per-row control; bit 0 = row enable; other bits reserved and ignored.
REQ-011 commonControl  input  3*depth+2*A  packed MSB to LSB: {Tc, Tr, kernelStep, neuronStep, convDivIniValue}.
REQ-012 kernelIn  input  W  kernel word from the row kernel buffer.
REQ-013 neuronIn  input  W  neuron word from the column neuron buffer.

Function
REQ-014 Local kernel memory kMem and neuron memory nMem, each 2^A x W; write synchronous, read combinational.
REQ-015 State: write pointers wK, wN (A bits); kBase, nBase, kCnt (A bits); convolution divider cd and row counter rc (depth bits).
REQ-016 When start=1: wK, wN, kBase, nBase, kCnt, rc <= 0 and cd <= convDivIniValue; no memory write or address advance that cycle; adderOut <= adderIn.
REQ-017 LOAD_KERNEL with rowControl[0]=1: kMem[wK] <= kernelIn and wK <= wK+1 mod 2^A; with rowControl[0]=0, no write and no pointer change.
REQ-018 LOAD_NEURON: nMem[wN] <= neuronIn and wN <= wN+1 mod 2^A, regardless of rowControl.
REQ-019 COMPUTE with rowControl[0]=1: product = low W bits of signed kMem[kBase+kCnt] * nMem[nBase+kCnt], addresses mod 2^A; adderOut <= adderIn + product, truncated to W bits (wrap, no saturation).
REQ-020 In all other cases (NOP, LOAD_*, or COMPUTE with rowControl[0]=0): adderOut <= adderIn; latency is always exactly 1 cycle.
REQ-021 Address advance, only on a COMPUTE cycle with rowControl[0]=1: if kCnt == kernelStep-1 then kCnt <= 0 and a kernel wrap occurs; otherwise kCnt <= kCnt+1.
REQ-022 On kernel wrap: if cd == Tc-1 (mod 2^depth) then cd <= 0 and nBase <= nBase+neuronStep and a neuron advance occurs; otherwise cd <= cd+1.
REQ-023 On neuron advance: if rc == Tr-1 (mod 2^depth) then rc <= 0 and kBase <= kBase+kernelStep; otherwise rc <= rc+1.
REQ-024 kernelStep=0 is treated as 2^A, Tc=0 as 2^depth, and Tr=0 as 2^depth, via modular comparison; base addition wraps mod 2^A.
REQ-025 commonControl is sampled every cycle; changes take effect immediately.

Reset
REQ-026 RESETn=0 asynchronously clears adderOut, wK, wN, kBase, nBase, kCnt, cd and rc to 0.
REQ-027 Memory contents are not reset.
REQ-028 The first edge after deassertion behaves as a normal cycle.

Verification
REQ-029 Reset: RESETn=0 mid-COMPUTE -> adderOut=0 immediately, before any clock edge.
REQ-030 Pass-through: op=NOP, adderIn=5 -> adderOut=5 one edge later; same result with COMPUTE and rowControl=0.
REQ-031 MAC: load kMem={2,3} (rowControl=1), load nMem={4,5}, start, kernelStep=2, then COMPUTE twice with adderIn=0 and then 10 -> adderOut=8, then 25.
REQ-032 Row gating: LOAD_KERNEL with rowControl=0 and kernelIn=9 -> kMem and wK unchanged.
REQ-033 Wrap: product 1 with adderIn=127 -> adderOut=0x80 (-128); kMem=-128, nMem=2 -> product 0.
REQ-034 Stepping: Tc=2, Tr=2, kernelStep=4, neuronStep=4, convDivIniValue=0 -> after 4 COMPUTE cycles cd=1 and nBase=0; after 8 cycles nBase=4 and rc=1; after 16 cycles kBase=4 and nBase=8.
